// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: state encoding and wait-counter width helper for the DMEM port arbiter
package dmem_arb_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DBG_ACC = 2'd1;
  localparam logic [1:0] DBG_ACK = 2'd2;
  function automatic int wait_w(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction
endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: saturating count of blocked debug cycles; hit forces a debug grant
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);
  localparam int WAIT_W = wait_w(MAX_WAIT);
  logic [WAIT_W-1:0] cnt;
  assign hit = cnt == WAIT_W'(MAX_WAIT);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !hit) cnt <= cnt + WAIT_W'(1);
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one DMEM port between the CPU (fixed priority) and a debug requester.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_cs,
  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [1:0]        state;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we;
  logic              grant;
  logic              hit;
  logic              dbg_own;
  assign dbg_own   = state == DBG_ACC;
  assign grant     = state == IDLE && dbg_req && (!cpu_cs || hit);
  assign dbg_ack   = state == DBG_ACK;
  assign cpu_stall = dbg_own && cpu_cs;
  assign cpu_rdata = mem_rdata;
  assign mem_cs    = dbg_own ? 1'b1 : cpu_cs;
  assign mem_r     = dbg_own ? !acc_we : cpu_r;
  assign mem_w     = dbg_own ? acc_we : cpu_w;
  assign mem_addr  = dbg_own ? acc_addr : cpu_addr;
  assign mem_wdata = dbg_own ? acc_wdata : cpu_wdata;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk(clk),
    .rst(rst),
    .clr(!dbg_req || grant),
    .inc(state == IDLE && dbg_req && cpu_cs),
    .hit(hit)
  );
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_we    <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= grant ? DBG_ACC : dbg_own ? DBG_ACK : IDLE;
      if (grant) begin
        acc_addr  <= dbg_addr;
        acc_wdata <= dbg_wdata;
        acc_we    <= dbg_we;
      end
      if (dbg_own && !acc_we) dbg_rdata <= mem_rdata;
    end
endmodule
